// File: rtl/jk_bank_driver_pkg.sv
// Shared types and constants for the JK bank driver.
// The optional bulk preset/clear path is enabled by the JKDRV_BULK_EN macro.
package jk_bank_driver_pkg;

    localparam int unsigned STATE_W = 2;
    localparam int unsigned JK_W    = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2
    } state_e;

    // Excitation codes are packed as {J, K}
    localparam logic [JK_W-1:0] JK_HOLD  = 2'b00;
    localparam logic [JK_W-1:0] JK_RESET = 2'b01;
    localparam logic [JK_W-1:0] JK_SET   = 2'b10;

    // Minimal excitation for one flip-flop; the toggle code is never produced
    function automatic logic [JK_W-1:0] jk_code(input logic q, input logic t);
        logic [JK_W-1:0] code;
        case ({q, t})
            2'b01:   code = JK_SET;
            2'b10:   code = JK_RESET;
            default: code = JK_HOLD;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/jk_bank_driver_if.sv
// Target handshake and JK bank connection bundle for jk_bank_driver.
// slave is the driver side; master is the requester plus the bank feedback.
interface jk_bank_driver_if #(
    parameter int unsigned WIDTH = 4
);
    logic             tgt_valid;
    logic             tgt_ready;
    logic [WIDTH-1:0] tgt_data;
    logic [WIDTH-1:0] q_fb;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic             preset;
    logic             clr;
    logic             busy;
    logic             done;
    logic             err;

    modport master (
        output tgt_valid, tgt_data, q_fb,
        input  tgt_ready, j, k, preset, clr, busy, done, err
    );

    modport slave (
        input  tgt_valid, tgt_data, q_fb,
        output tgt_ready, j, k, preset, clr, busy, done, err
    );
endinterface

// File: rtl/jk_excite.sv
// Combinational per-bit J/K excitation from current Q and target word.
module jk_excite
    import jk_bank_driver_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] t,
    output logic [WIDTH-1:0] j_c,
    output logic [WIDTH-1:0] k_c
);

    always_comb begin
        j_c = '0;
        k_c = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            {j_c[i], k_c[i]} = jk_code(q[i], t[i]);
        end
    end

endmodule

// File: rtl/jk_bank_driver.sv
// Drives a JK flip-flop bank toward a target word, verifies it and retries.
// Define JKDRV_BULK_EN to use bank clear/preset for all-zero/all-one targets.
module jk_bank_driver
    import jk_bank_driver_pkg::*;
#(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned MAX_RETRY = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    jk_bank_driver_if.slave   bus
);

    localparam int unsigned CNT_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    localparam logic [STATE_W-1:0] S_IDLE  = IDLE;
    localparam logic [STATE_W-1:0] S_DRIVE = DRIVE;
    localparam logic [STATE_W-1:0] S_CHECK = CHECK;

    logic [STATE_W-1:0] state_q, state_d;
    logic [WIDTH-1:0]   tgt_q, tgt_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ready_q, ready_d;
    logic               busy_q, busy_d;
    logic [WIDTH-1:0]   j_q, j_d;
    logic [WIDTH-1:0]   k_q, k_d;
    logic               preset_q, preset_d;
    logic               clr_q, clr_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic [WIDTH-1:0]   exc_t;
    logic [WIDTH-1:0]   exc_j;
    logic [WIDTH-1:0]   exc_k;
    logic [WIDTH-1:0]   drv_j;
    logic [WIDTH-1:0]   drv_k;
    logic               drv_preset;
    logic               drv_clr;

    // Fresh target while idle, captured target on retries
    assign exc_t = (state_q == S_IDLE) ? bus.tgt_data : tgt_q;

    jk_excite #(.WIDTH(WIDTH)) u_excite (
        .q   (bus.q_fb),
        .t   (exc_t),
        .j_c (exc_j),
        .k_c (exc_k)
    );

    // Drive pattern for the next DRIVE cycle
    always_comb begin
        drv_j      = exc_j;
        drv_k      = exc_k;
        drv_preset = 1'b0;
        drv_clr    = 1'b0;
`ifdef JKDRV_BULK_EN
        if (exc_t == '0) begin
            drv_j   = '0;
            drv_k   = '0;
            drv_clr = 1'b1;
        end else if (exc_t == '1) begin
            drv_j      = '0;
            drv_k      = '0;
            drv_preset = 1'b1;
        end
`endif
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            tgt_q    <= '0;
            cnt_q    <= '0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
            j_q      <= '0;
            k_q      <= '0;
            preset_q <= 1'b0;
            clr_q    <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            tgt_q    <= tgt_d;
            cnt_q    <= cnt_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
            j_q      <= j_d;
            k_q      <= k_d;
            preset_q <= preset_d;
            clr_q    <= clr_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    // Next state and next output values
    always_comb begin
        state_d  = state_q;
        tgt_d    = tgt_q;
        cnt_d    = cnt_q;
        ready_d  = 1'b0;
        busy_d   = 1'b0;
        j_d      = '0;
        k_d      = '0;
        preset_d = 1'b0;
        clr_d    = 1'b0;
        done_d   = 1'b0;
        err_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                ready_d = 1'b1;
                if (bus.tgt_valid && ready_q) begin
                    tgt_d    = bus.tgt_data;
                    cnt_d    = '0;
                    state_d  = S_DRIVE;
                    ready_d  = 1'b0;
                    busy_d   = 1'b1;
                    j_d      = drv_j;
                    k_d      = drv_k;
                    preset_d = drv_preset;
                    clr_d    = drv_clr;
                end
            end
            S_DRIVE: begin
                state_d = S_CHECK;
                busy_d  = 1'b1;
            end
            S_CHECK: begin
                if (bus.q_fb == tgt_q) begin
                    state_d = S_IDLE;
                    ready_d = 1'b1;
                    done_d  = 1'b1;
                end else if (cnt_q < CNT_W'(MAX_RETRY)) begin
                    cnt_d    = cnt_q + CNT_W'(1);
                    state_d  = S_DRIVE;
                    busy_d   = 1'b1;
                    j_d      = drv_j;
                    k_d      = drv_k;
                    preset_d = drv_preset;
                    clr_d    = drv_clr;
                end else begin
                    state_d = S_IDLE;
                    ready_d = 1'b1;
                    err_d   = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.tgt_ready = ready_q;
    assign bus.busy      = busy_q;
    assign bus.j         = j_q;
    assign bus.k         = k_q;
    assign bus.preset    = preset_q;
    assign bus.clr       = clr_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_jk_bank_driver.sv
// Self-checking bench for jk_bank_driver driving a 4-bit JK bank model.
// Expected traces come from a transaction-level model of the drive/verify/retry rules.
module tb_jk_bank_driver;

    localparam int unsigned WIDTH     = 4;
    localparam int unsigned MAX_RETRY = 3;
    localparam int          TRACE_MAX = 16;
`ifdef JKDRV_BULK_EN
    localparam bit BULK = 1'b1;
`else
    localparam bit BULK = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b1;

    jk_bank_driver_if #(.WIDTH(WIDTH)) bus ();

    jk_bank_driver #(.WIDTH(WIDTH), .MAX_RETRY(MAX_RETRY)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Bench JK bank with synchronous preset/clear, a load port and stuck-at-0 outputs
    logic [3:0] bank_q = 4'h0;
    logic [3:0] stuck = 4'h0;
    logic [3:0] load_val = 4'h0;
    logic       load_en = 1'b0;

    assign bus.q_fb = bank_q & ~stuck;

    always @(posedge clk) begin
        if (load_en)         bank_q <= load_val;
        else if (bus.preset) bank_q <= 4'hF;
        else if (bus.clr)    bank_q <= 4'h0;
        else                 bank_q <= (bus.j & ~bank_q) | (~bus.k & bank_q);
    end

    int n_cmp = 0;
    int n_fail = 0;

    // Observed per-cycle trace starting with the cycle after the handshake edge
    logic [3:0] tr_j [TRACE_MAX];
    logic [3:0] tr_k [TRACE_MAX];
    logic [3:0] tr_q [TRACE_MAX];
    logic       tr_pre [TRACE_MAX];
    logic       tr_clr [TRACE_MAX];
    logic       tr_busy [TRACE_MAX];
    logic       tr_rdy [TRACE_MAX];
    logic       tr_done [TRACE_MAX];
    logic       tr_err [TRACE_MAX];
    int         n_cyc;
    logic       timed_out;

    // Expected trace from the model
    logic [3:0] ex_j [TRACE_MAX];
    logic [3:0] ex_k [TRACE_MAX];
    logic       ex_pre [TRACE_MAX];
    logic       ex_clr [TRACE_MAX];
    int         ex_n;
    logic       ex_ok;

    // Transaction model: each attempt sets bits the target wants high, resets the others
    task automatic model_txn(input logic [3:0] q0, input logic [3:0] t, input logic [3:0] sm);
        logic [3:0] q;
        q     = q0 & ~sm;
        ex_ok = 1'b0;
        ex_n  = 0;
        for (int a = 0; a <= int'(MAX_RETRY) && !ex_ok; a++) begin
            ex_j[2*a]   = ~q & t;
            ex_k[2*a]   = q & ~t;
            ex_pre[2*a] = 1'b0;
            ex_clr[2*a] = 1'b0;
            if (BULK && t == 4'h0) begin
                ex_j[2*a] = 4'h0; ex_k[2*a] = 4'h0; ex_clr[2*a] = 1'b1;
            end else if (BULK && t == 4'hF) begin
                ex_j[2*a] = 4'h0; ex_k[2*a] = 4'h0; ex_pre[2*a] = 1'b1;
            end
            ex_j[2*a+1]   = 4'h0;
            ex_k[2*a+1]   = 4'h0;
            ex_pre[2*a+1] = 1'b0;
            ex_clr[2*a+1] = 1'b0;
            q     = t & ~sm;
            ex_ok = (q == t);
            ex_n  = 2*a + 3;
        end
    endtask

    task automatic wait_ready();
        int w = 0;
        while (bus.tgt_ready !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        n_cmp++;
        if (bus.tgt_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_wait: tgt_ready=%b required 1 within 20 cycles", bus.tgt_ready);
        end
    endtask

    // Load the bank, offer one target and record outputs until done/err or budget
    task automatic do_txn(input logic [3:0] q0, input logic [3:0] t, input logic [3:0] sm);
        logic fin;
        wait_ready();
        stuck    = sm;
        load_val = q0;
        load_en  = 1'b1;
        @(negedge clk);
        load_en       = 1'b0;
        bus.tgt_data  = t;
        bus.tgt_valid = 1'b1;
        @(negedge clk);
        bus.tgt_valid = 1'b0;
        bus.tgt_data  = 4'($urandom);
        for (int c = 0; c < TRACE_MAX; c++) begin
            tr_done[c] = 1'b0; tr_err[c] = 1'b0; tr_busy[c] = 1'b0; tr_rdy[c] = 1'b0;
        end
        n_cyc = 0;
        fin   = 1'b0;
        for (int c = 0; c < TRACE_MAX && !fin; c++) begin
            if (c > 0) @(negedge clk);
            tr_j[c]    = bus.j;
            tr_k[c]    = bus.k;
            tr_q[c]    = bus.q_fb;
            tr_pre[c]  = bus.preset;
            tr_clr[c]  = bus.clr;
            tr_busy[c] = bus.busy;
            tr_rdy[c]  = bus.tgt_ready;
            tr_done[c] = bus.done;
            tr_err[c]  = bus.err;
            n_cyc      = c + 1;
            fin        = bus.done | bus.err;
        end
        timed_out = !fin;
        n_cmp++;
        if (timed_out) begin
            n_fail++;
            $display("FAIL txn_timeout: no done/err after %0d cycles, required one", TRACE_MAX);
        end
    endtask

    task automatic test_reset();
        bus.tgt_valid = 1'b0;
        bus.tgt_data  = 4'h0;
        stuck    = 4'h0;
        load_val = 4'h0;
        load_en  = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({bus.tgt_ready, bus.busy, bus.done, bus.err, bus.preset, bus.clr, bus.j, bus.k} !== 14'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: rdy/busy/done/err/pre/clr/j/k=%h required 0",
                {bus.tgt_ready, bus.busy, bus.done, bus.err, bus.preset, bus.clr, bus.j, bus.k});
        end
        @(negedge clk);
        @(negedge clk);
        load_en = 1'b0;
        n_cmp++;
        if (bus.tgt_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_held_ready: tgt_ready=%b required 0", bus.tgt_ready);
        end
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if (bus.tgt_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL release_ready: tgt_ready=%b required 0 before first edge", bus.tgt_ready);
        end
        @(negedge clk);
        n_cmp++;
        if ({bus.tgt_ready, bus.busy} !== 2'b10) begin
            n_fail++;
            $display("FAIL first_edge_ready: ready,busy=%b required 10", {bus.tgt_ready, bus.busy});
        end
    endtask

    task automatic test_basic_set_reset();
        do_txn(4'b0110, 4'b1010, 4'h0);
        n_cmp++;
        if (n_cyc !== 3) begin
            n_fail++; $display("FAIL basic_latency: cycles=%0d required 3", n_cyc);
        end
        n_cmp++;
        if ({tr_j[0], tr_k[0], tr_pre[0], tr_clr[0]} !== {4'b1000, 4'b0100, 2'b00}) begin
            n_fail++;
            $display("FAIL basic_drive: j=%b k=%b pre=%b clr=%b required j=1000 k=0100 pre=0 clr=0",
                tr_j[0], tr_k[0], tr_pre[0], tr_clr[0]);
        end
        n_cmp++;
        if ({tr_busy[0], tr_rdy[0]} !== 2'b10) begin
            n_fail++; $display("FAIL basic_busy: busy,ready=%b required 10", {tr_busy[0], tr_rdy[0]});
        end
        n_cmp++;
        if ({tr_q[1], tr_j[1], tr_k[1]} !== {4'b1010, 8'h00}) begin
            n_fail++;
            $display("FAIL basic_check: q=%b j=%b k=%b required q=1010 j=k=0", tr_q[1], tr_j[1], tr_k[1]);
        end
        n_cmp++;
        if ({tr_done[2], tr_err[2], tr_rdy[2], tr_busy[2]} !== 4'b1010) begin
            n_fail++;
            $display("FAIL basic_done: done,err,ready,busy=%b required 1010",
                {tr_done[2], tr_err[2], tr_rdy[2], tr_busy[2]});
        end
    endtask

    task automatic test_target_equals_q();
        do_txn(4'b0101, 4'b0101, 4'h0);
        n_cmp++;
        if ({tr_j[0], tr_k[0], tr_busy[0]} !== 9'b0000_0000_1) begin
            n_fail++;
            $display("FAIL equal_drive: j=%b k=%b busy=%b required j=k=0000 busy=1", tr_j[0], tr_k[0], tr_busy[0]);
        end
        n_cmp++;
        if (n_cyc !== 3 || tr_done[2] !== 1'b1) begin
            n_fail++; $display("FAIL equal_done: cycles=%0d done=%b required 3 and 1", n_cyc, tr_done[2]);
        end
    endtask

    task automatic test_retry_exhaustion();
        logic any_done;
        do_txn(4'b0000, 4'b0001, 4'b0001);
        n_cmp++;
        if (n_cyc !== 2 * int'(MAX_RETRY) + 3) begin
            n_fail++; $display("FAIL retry_len: cycles=%0d required %0d", n_cyc, 2 * MAX_RETRY + 3);
        end
        for (int a = 0; a <= int'(MAX_RETRY); a++) begin
            n_cmp++;
            if ({tr_j[2*a][0], tr_k[2*a][0], tr_busy[2*a], tr_busy[2*a+1]} !== 4'b1011) begin
                n_fail++;
                $display("FAIL retry_drive%0d: j0,k0,busy,busy_next=%b required 1011", a,
                    {tr_j[2*a][0], tr_k[2*a][0], tr_busy[2*a], tr_busy[2*a+1]});
            end
        end
        any_done = 1'b0;
        for (int c = 0; c < TRACE_MAX; c++) any_done = any_done | tr_done[c];
        n_cmp++;
        if ({tr_err[2*MAX_RETRY+2], tr_rdy[2*MAX_RETRY+2], any_done} !== 3'b110) begin
            n_fail++;
            $display("FAIL retry_err: err,ready,any_done=%b required 110",
                {tr_err[2*MAX_RETRY+2], tr_rdy[2*MAX_RETRY+2], any_done});
        end
    endtask

    task automatic test_reset_mid_drive();
        wait_ready();
        stuck = 4'h0; load_val = 4'h0; load_en = 1'b1;
        @(negedge clk);
        load_en = 1'b0;
        bus.tgt_data = 4'b1010; bus.tgt_valid = 1'b1;
        @(negedge clk);
        bus.tgt_valid = 1'b0;
        n_cmp++;
        if ({bus.busy, bus.j} !== 5'b1_1010) begin
            n_fail++; $display("FAIL middrv_enter: busy,j=%b required 1_1010", {bus.busy, bus.j});
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({bus.j, bus.k, bus.busy, bus.done, bus.err} !== 11'h0) begin
            n_fail++;
            $display("FAIL middrv_reset: j=%b k=%b busy=%b done=%b err=%b required all 0",
                bus.j, bus.k, bus.busy, bus.done, bus.err);
        end
        @(negedge clk);
        n_cmp++;
        if ({bus.q_fb, bus.done, bus.err} !== 6'h0) begin
            n_fail++; $display("FAIL middrv_bank: q=%b done=%b err=%b required 0000 0 0", bus.q_fb, bus.done, bus.err);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({bus.tgt_ready, bus.done, bus.err, bus.q_fb} !== 7'b100_0000) begin
            n_fail++;
            $display("FAIL middrv_release: ready=%b done=%b err=%b q=%b required 1 0 0 0000",
                bus.tgt_ready, bus.done, bus.err, bus.q_fb);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] ej, ek;
        wait_ready();
        stuck = 4'h0; load_val = 4'b0110; load_en = 1'b1;
        @(negedge clk);
        load_en = 1'b0;
        bus.tgt_data = 4'hF; bus.tgt_valid = 1'b1;
        @(negedge clk);
        bus.tgt_data = 4'h0;
        ej = BULK ? 4'h0 : 4'b1001;
        n_cmp++;
        if ({bus.tgt_ready, bus.busy, bus.j, bus.k, bus.preset, bus.clr} !== {2'b01, ej, 4'h0, BULK, 1'b0}) begin
            n_fail++;
            $display("FAIL b2b_first_drive: ready=%b busy=%b j=%b k=%b pre=%b clr=%b required 0 1 %b 0000 %b 0",
                bus.tgt_ready, bus.busy, bus.j, bus.k, bus.preset, bus.clr, ej, BULK);
        end
        @(negedge clk);
        n_cmp++;
        if ({bus.tgt_ready, bus.busy, bus.done, bus.j, bus.k} !== {3'b010, 8'h00}) begin
            n_fail++;
            $display("FAIL b2b_busy_reject: ready=%b busy=%b done=%b j=%b k=%b required 0 1 0 0 0",
                bus.tgt_ready, bus.busy, bus.done, bus.j, bus.k);
        end
        @(negedge clk);
        n_cmp++;
        if ({bus.done, bus.err, bus.tgt_ready} !== 3'b101) begin
            n_fail++; $display("FAIL b2b_first_done: done,err,ready=%b required 101", {bus.done, bus.err, bus.tgt_ready});
        end
        @(negedge clk);
        bus.tgt_valid = 1'b0;
        ek = BULK ? 4'h0 : 4'hF;
        n_cmp++;
        if ({bus.tgt_ready, bus.busy, bus.j, bus.k, bus.preset, bus.clr} !== {2'b01, 4'h0, ek, 1'b0, BULK}) begin
            n_fail++;
            $display("FAIL b2b_second_drive: ready=%b busy=%b j=%b k=%b pre=%b clr=%b required 0 1 0000 %b 0 %b",
                bus.tgt_ready, bus.busy, bus.j, bus.k, bus.preset, bus.clr, ek, BULK);
        end
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if ({bus.done, bus.err, bus.q_fb} !== 6'b10_0000) begin
            n_fail++; $display("FAIL b2b_second_done: done=%b err=%b q=%b required 1 0 0000", bus.done, bus.err, bus.q_fb);
        end
    endtask

    task automatic test_random();
        logic [3:0] q0, t, sm;
        for (int it = 0; it < 24; it++) begin
            q0 = 4'($urandom);
            case ($urandom_range(0, 5))
                0:       t = q0;
                1:       t = 4'h0;
                2:       t = 4'hF;
                default: t = 4'($urandom);
            endcase
            sm = ($urandom_range(0, 3) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'h0;
            model_txn(q0, t, sm);
            do_txn(q0, t, sm);
            n_cmp++;
            if (n_cyc !== ex_n) begin
                n_fail++;
                $display("FAIL rnd%0d_len: q0=%b t=%b stuck=%b cycles=%0d required %0d", it, q0, t, sm, n_cyc, ex_n);
            end
            for (int c = 0; c < ex_n - 1 && c < n_cyc; c++) begin
                n_cmp++;
                if ({tr_j[c], tr_k[c], tr_pre[c], tr_clr[c], tr_busy[c], tr_done[c], tr_err[c]} !==
                    {ex_j[c], ex_k[c], ex_pre[c], ex_clr[c], 3'b100}) begin
                    n_fail++;
                    $display("FAIL rnd%0d_cyc%0d: j=%b k=%b pre=%b clr=%b busy=%b done=%b err=%b required j=%b k=%b pre=%b clr=%b busy=1 done=0 err=0",
                        it, c, tr_j[c], tr_k[c], tr_pre[c], tr_clr[c], tr_busy[c], tr_done[c], tr_err[c],
                        ex_j[c], ex_k[c], ex_pre[c], ex_clr[c]);
                end
            end
            n_cmp++;
            if ({tr_done[ex_n-1], tr_err[ex_n-1], tr_rdy[ex_n-1], tr_busy[ex_n-1]} !== {ex_ok, !ex_ok, 2'b10}) begin
                n_fail++;
                $display("FAIL rnd%0d_end: done=%b err=%b ready=%b busy=%b required done=%b err=%b ready=1 busy=0",
                    it, tr_done[ex_n-1], tr_err[ex_n-1], tr_rdy[ex_n-1], tr_busy[ex_n-1], ex_ok, !ex_ok);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_set_reset();
        test_target_equals_q();
        test_retry_exhaustion();
        test_reset_mid_drive();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish by 200000, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/jk_bank_driver.md
Name: jk_bank_driver

Overview:
- Controller that drives a bank of WIDTH synchronous JK flip-flops with preset/clear toward a requested target word.
- For each bit it computes the J/K excitation from the current Q and the target, applies it for one clock, then reads Q back and verifies it.
- If Q does not match, it re-drives up to MAX_RETRY times.
- It sits upstream of the JK register bank: the bank's J, K, preset and clr inputs come from this block, and the bank's q outputs return on q_fb.

Parameters:
- WIDTH, 4, number of JK flip-flops driven.
- MAX_RETRY, 3, number of extra drive attempts after the first mismatch (0 means a single attempt).

Ports:
- clk  in  1  rising-edge clock, shared with the JK bank.
- rst_n  in  1  asynchronous active-low reset.
- tgt_valid  in  1  target word offered.
- tgt_ready  out  1  block idle and able to accept a target.
- tgt_data  in  WIDTH  requested Q value.
- q_fb  in  WIDTH  q outputs of the JK bank.
- j  out  WIDTH  J inputs to the bank.
- k  out  WIDTH  K inputs to the bank.
- preset  out  1  bank synchronous preset.
- clr  out  1  bank synchronous clear.
- busy  out  1  a transaction is in progress.
- done  out  1  one-cycle pulse: bank verified equal to target.
- err  out  1  one-cycle pulse: retries exhausted without a match.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; j=0, k=0, preset=0, clr=0, busy=0, done=0, err=0, tgt_ready=0, retry count=0.
  - tgt_ready rises at the first clk edge after rst_n deasserts.
  - Reset mid-transaction aborts with no done/err and leaves j/k at 00, so the bank holds its value.
- All outputs are registered.
- States:
  - IDLE: tgt_ready=1, busy=0, j=k=0.
    - On tgt_valid&tgt_ready at an edge: capture tgt_data; compute excitation from q_fb sampled at that edge; go to DRIVE; retry count=0.
  - DRIVE: j/k hold the computed excitation for exactly one cycle; busy=1, tgt_ready=0. The bank samples j/k at the edge ending DRIVE. Next state is CHECK with j=k=0.
  - CHECK: compare q_fb to the captured target.
    - Equal: go to IDLE; done=1 for one cycle.
    - Unequal and count<MAX_RETRY: count+1; re-compute excitation from the current q_fb; go to DRIVE.
    - Unequal and count==MAX_RETRY: go to IDLE; err=1 for one cycle.
- Excitation per bit (q, t -> J, K):
  - 0,0 -> 0,0
  - 0,1 -> 1,0
  - 1,0 -> 0,1
  - 1,1 -> 0,0
  - Don't-care terms resolve to 0. The toggle code 11 is never issued.
- Latency with no retries: handshake edge E0, DRIVE cycle, bank update at E1, CHECK cycle, done high in the cycle after E2.
- Boundary cases:
  - Target equal to current Q: 00 excitation; done still after E2.
  - tgt_valid while busy: ignored; tgt_ready=0.
  - tgt_data changes after capture: no effect.
  - done and err are never asserted together.
  - tgt_ready=1 in the same cycle as done/err, so back-to-back transactions are allowed.
- Without JKDRV_BULK_EN, preset and clr are tied 0.

Optional Feature:
- Macro: JKDRV_BULK_EN.
- When defined and the captured target is all zeros, DRIVE asserts clr=1 with j=k=0 instead of per-bit excitation.
- When the target is all ones, DRIVE asserts preset=1.
- clr and preset are never asserted together. Each is a one-cycle pulse, same timing as j/k, and retries use the same bulk path.
- Without the macro, only per-bit J/K excitation is used and preset=clr=0 always.

Decomposition:
- Package jk_bank_driver_pkg:
  - state enum {IDLE, DRIVE, CHECK};
  - 2-bit excitation constants JK_HOLD=2'b00, JK_RESET=2'b01, JK_SET=2'b10.
- Sub-module jk_excite: combinational, per WIDTH vector (q, t) -> (j, k). It is instantiated once and reused for the initial drive and for retries.

Test Plan:
- All tests use WIDTH=4 and a bench bank of 4 of the team's JK flip-flops.
- Reset mid-DRIVE:
  - Stimulus: q=0000, target 1010, rst_n pulsed low during DRIVE.
  - Response: j=k=0 immediately; bank stays 0000; no done/err; tgt_ready=1 one edge after release.
- Basic set/reset:
  - Stimulus: q=0110, target 1010.
  - Response: DRIVE shows j=1000, k=0100; q=1010 after E1; done pulse after E2; err=0.
- Target equals Q:
  - Stimulus: q=0101, target 0101.
  - Response: j=k=0000; done after E2.
- Retry exhaustion:
  - Stimulus: bench forces bit0 stuck at 0, target 0001.
  - Response: 4 DRIVE cycles (MAX_RETRY=3) each with j[0]=1; err pulse; no done; tgt_ready returns.
- Back-to-back plus busy rejection:
  - Stimulus: target 1111 then 0000; tgt_valid held through busy.
  - Response: second target accepted only in the done cycle; both complete.
  - With JKDRV_BULK_EN: preset then clr pulse, j=k=0.
